// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants, state type and helpers for the Viterbi decode controller
package viterbi_pkg;

  localparam int WINDOW    = 8;
  localparam int PTR_W     = 3;
  localparam int FLUSH_LEN = 7;
  localparam int NORM_BIT  = 3;
  localparam int METRIC_W  = 4;
  localparam int PATH_W    = 8;
  localparam int FILL_W    = $clog2(WINDOW + 1);
  localparam int FLUSH_W   = $clog2(FLUSH_LEN);
  localparam int BITCNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STEADY = 2'd2,
    FLUSH  = 2'd3
  } dec_state_t;

  function automatic logic [BITCNT_W-1:0] sat_inc(input logic [BITCNT_W-1:0] v);
    return (v == {BITCNT_W{1'b1}}) ? v : v + BITCNT_W'(1);
  endfunction

endpackage

// File: rtl/decode_ctrl_if.sv
// rtl/decode_ctrl_if.sv - symbol handshake and ACS/selector control bundle of the decode controller
interface decode_ctrl_if;
  import viterbi_pkg::*;

  logic                sym_valid_in;
  logic                sym_ready_out;
  logic                frame_start;
  logic                frame_end;
  logic [METRIC_W-1:0] min_metric_in;
  logic                acs_en;
  logic                tail;
  logic                metric_norm;
  logic [PTR_W-1:0]    write_pointer;
  logic                sel_valid;
  logic [BITCNT_W-1:0] bit_count;
  logic                frame_err;
  logic                busy;

  modport slave (
    input  sym_valid_in, frame_start, frame_end, min_metric_in,
    output sym_ready_out, acs_en, tail, metric_norm, write_pointer,
           sel_valid, bit_count, frame_err, busy
  );

  modport master (
    output sym_valid_in, frame_start, frame_end, min_metric_in,
    input  sym_ready_out, acs_en, tail, metric_norm, write_pointer,
           sel_valid, bit_count, frame_err, busy
  );

endinterface

// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - frame FSM sequencing ACS steps, survivor slots, traceback valids and tail flush
module decode_ctrl
  import viterbi_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  decode_ctrl_if.slave bus
);

  localparam logic [FILL_W-1:0]   C_WINDOW    = FILL_W'(WINDOW);
  localparam logic [FLUSH_W-1:0]  C_FLUSH_END = FLUSH_W'(FLUSH_LEN - 1);
  localparam logic [METRIC_W-1:0] C_NORM_THR  = METRIC_W'(1 << NORM_BIT);

  dec_state_t          r_state;
  dec_state_t          w_state_nxt;
  logic [PTR_W-1:0]    r_wp;
  logic [FILL_W-1:0]   r_fill;
  logic [FLUSH_W-1:0]  r_flush;
  logic                r_sel;
  logic                r_norm;
  logic                r_err;
  logic [BITCNT_W-1:0] r_bits;

  logic                w_ready;
  logic                w_accept;
  logic                w_acs;
  logic                w_start;
  logic                w_err;
  logic                w_flush_done;
  logic                w_sel_step;
  logic                w_norm_req;
  logic [FILL_W-1:0]   w_fill_inc;

  // fill count saturates at the window so it doubles as the "traceback ready" flag
  assign w_fill_inc   = (r_fill == C_WINDOW) ? r_fill : r_fill + FILL_W'(1);
  assign w_sel_step   = w_acs && (w_fill_inc == C_WINDOW);
  assign w_norm_req   = (bus.min_metric_in >= C_NORM_THR);
  assign w_flush_done = (r_state == FLUSH) && (r_flush == C_FLUSH_END);

  always_comb begin
    w_state_nxt = r_state;
    w_acs       = 1'b0;
    w_start     = 1'b0;
    w_err       = 1'b0;
    w_ready     = (r_state != FLUSH);
    w_accept    = w_ready && bus.sym_valid_in && !rst;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.frame_start) begin
            w_acs       = 1'b1;
            w_start     = 1'b1;
            w_state_nxt = bus.frame_end ? FLUSH : FILL;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      FILL: begin
        if (w_accept) begin
          w_acs = 1'b1;
          w_err = bus.frame_start;
          if (bus.frame_end) begin
            w_state_nxt = FLUSH;
          end else if (w_fill_inc == C_WINDOW) begin
            w_state_nxt = STEADY;
          end
        end
      end
      STEADY: begin
        if (w_accept) begin
          w_acs = 1'b1;
          w_err = bus.frame_start;
          if (bus.frame_end) begin
            w_state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        w_acs = 1'b1;
        if (w_flush_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err;
      r_sel   <= w_sel_step;
    end
  end

  // pointer and fill restart at zero when a frame drains, so an idle controller always points at slot 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp   <= '0;
      r_fill <= '0;
    end else if (w_start) begin
      r_wp   <= PTR_W'(1);
      r_fill <= FILL_W'(1);
    end else if (w_flush_done) begin
      r_wp   <= '0;
      r_fill <= '0;
    end else if (w_acs) begin
      r_wp   <= r_wp + PTR_W'(1);
      r_fill <= w_fill_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush <= '0;
    end else if (r_state == FLUSH) begin
      r_flush <= w_flush_done ? '0 : r_flush + FLUSH_W'(1);
    end else begin
      r_flush <= '0;
    end
  end

  // a pending normalisation is held across idle gaps until the next step consumes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_norm <= 1'b0;
    end else if (w_start) begin
      r_norm <= w_norm_req;
    end else if (w_flush_done) begin
      r_norm <= 1'b0;
    end else if (w_acs) begin
      r_norm <= w_norm_req && !r_norm;
    end else if (r_state == IDLE) begin
      r_norm <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bits <= '0;
    end else if (w_start) begin
      r_bits <= '0;
    end else if (w_sel_step) begin
      r_bits <= sat_inc(r_bits);
    end
  end

  assign bus.sym_ready_out = w_ready;
  assign bus.acs_en        = w_acs;
  assign bus.tail          = (r_state == FLUSH);
  assign bus.metric_norm   = r_norm;
  assign bus.write_pointer = r_wp;
  assign bus.sel_valid     = r_sel;
  assign bus.bit_count     = r_bits;
  assign bus.frame_err     = r_err;
  assign bus.busy          = (r_state != IDLE);

endmodule
